// File: rtl/timer_irq_ctrl.sv
// Multi-channel down-counting timer with pending/overrun status, interrupt mask
// and a fixed-priority ID register. One counter sub-module per channel.

module timer_irq_chan #(
    parameter int CW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          start_i,
    input  logic [CW-1:0] period_i,
    output logic          fire_o
);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          live;

    // A zero period parks the channel: counter held, never fires.
    assign live   = (period_i != '0);
    assign fire_o = en_i && live && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (live) begin
            if (start_i)   cnt_d = period_i - ONE;
            else if (en_i) cnt_d = (cnt_q == '0) ? period_i - ONE : cnt_q - ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

module timer_irq_ctrl #(
    parameter int NCH = 4,
    parameter int CW  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        irq
);
    logic [NCH-1:0][CW-1:0] period_q, period_d;
    logic [NCH-1:0] en_q, en_d, os_q, os_d, mask_q, mask_d;
    logic [NCH-1:0] pend_q, pend_d, ovr_q, ovr_d;
    logic [NCH-1:0] fire, start, w1c_p, w1c_o, pm;
    logic [31:0]    rdata, readdata_q;
    logic [2:0]     id_ch;
    logic           ctrl_wr, mask_wr, stat_wr;

    assign ctrl_wr = write && (address == 4'd8);
    assign mask_wr = write && (address == 4'd9);
    assign stat_wr = write && (address == 4'd10);

    assign w1c_p = stat_wr ? writedata[NCH-1:0]  : '0;
    assign w1c_o = stat_wr ? writedata[8 +: NCH] : '0;
    // Only a 0->1 enable transition reloads; rewriting a set bit keeps the count.
    assign start = ctrl_wr ? (writedata[NCH-1:0] & ~en_q) : '0;

    for (genvar n = 0; n < NCH; n++) begin : g_chan
        timer_irq_chan #(.CW(CW)) u_chan (
            .clk_i    (clk),
            .rst_ni   (reset_n),
            .en_i     (en_q[n]),
            .start_i  (start[n]),
            .period_i (period_q[n]),
            .fire_o   (fire[n])
        );
    end

    always_comb begin
        period_d = period_q;
        for (int n = 0; n < NCH; n++)
            if (write && (address == 4'(n))) period_d[n] = writedata[CW-1:0];
        // A CTRL write in the same cycle as a one-shot fire takes precedence.
        en_d   = ctrl_wr ? writedata[NCH-1:0]  : (en_q & ~(fire & os_q));
        os_d   = ctrl_wr ? writedata[8 +: NCH] : os_q;
        mask_d = mask_wr ? writedata[NCH-1:0]  : mask_q;
        pend_d = (pend_q & ~w1c_p) | fire;
        ovr_d  = (ovr_q & ~w1c_o) | (fire & pend_q & ~w1c_p);
    end

    assign pm  = pend_q & mask_q;
    assign irq = |pm;

    always_comb begin
        id_ch = '0;
        for (int n = NCH - 1; n >= 0; n--)
            if (pm[n]) id_ch = 3'(n);
    end

    always_comb begin
        rdata = '0;
        for (int n = 0; n < NCH; n++)
            if (address == 4'(n)) rdata[CW-1:0] = period_q[n];
        case (address)
            4'd8:    rdata = {16'b0, 8'(os_q), 8'(en_q)};
            4'd9:    rdata = {24'b0, 8'(mask_q)};
            4'd10:   rdata = {16'b0, 8'(ovr_q), 8'(pend_q)};
            4'd11:   rdata = {irq, 28'b0, id_ch};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q   <= '0;
            en_q       <= '0;
            os_q       <= '0;
            mask_q     <= '0;
            pend_q     <= '0;
            ovr_q      <= '0;
            readdata_q <= '0;
        end else begin
            period_q <= period_d;
            en_q     <= en_d;
            os_q     <= os_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            if (read) readdata_q <= rdata;
        end
    end

    assign readdata = readdata_q;
endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: directed vector table, reset-pulse sequence and a
// randomized run against a fire-time scheduling model.

module tb_timer_irq_ctrl;
    localparam int NCH = 4;

    logic        clk, reset_n, write, read, irq;
    logic [3:0]  address;
    logic [31:0] writedata, readdata;

    timer_irq_ctrl #(.NCH(NCH), .CW(32)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata), .irq(irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each enabled channel holds the absolute edge number of its next fire.
    int          t = 0;
    int          nf   [NCH];
    bit          en   [NCH];
    bit          os   [NCH];
    bit          mask [NCH];
    bit          pend [NCH];
    bit          ovr  [NCH];
    logic [31:0] per  [NCH];
    logic [31:0] exp_rd = '0;

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            nf[n] = 0; en[n] = 0; os[n] = 0; mask[n] = 0;
            pend[n] = 0; ovr[n] = 0; per[n] = '0;
        end
        exp_rd = '0;
    endtask

    function automatic logic m_irq();
        logic v = 1'b0;
        for (int n = 0; n < NCH; n++) v |= pend[n] & mask[n];
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] v = '0;
        if (int'(a) < NCH) v = per[a];
        else if (a == 4'd8)  for (int n = 0; n < NCH; n++) begin v[n] = en[n];   v[8+n] = os[n];  end
        else if (a == 4'd9)  for (int n = 0; n < NCH; n++) v[n] = mask[n];
        else if (a == 4'd10) for (int n = 0; n < NCH; n++) begin v[n] = pend[n]; v[8+n] = ovr[n]; end
        else if (a == 4'd11) begin
            for (int n = NCH - 1; n >= 0; n--)
                if (pend[n] && mask[n]) v = {1'b1, 28'b0, 3'(n)};
        end
        return v;
    endfunction

    task automatic m_step(input logic w, input logic [3:0] a, input logic [31:0] d);
        bit fire [NCH];
        bit ne, wp, wo;
        t++;
        for (int n = 0; n < NCH; n++) fire[n] = en[n] && per[n] != 0 && nf[n] == t;
        for (int n = 0; n < NCH; n++) begin
            ne = (w && a == 4'd8) ? d[n] : (en[n] && !(fire[n] && os[n]));
            if ((ne && !en[n]) || fire[n]) nf[n] = t + int'(per[n]);
            wp = w && a == 4'd10 && d[n];
            wo = w && a == 4'd10 && d[8+n];
            ovr[n]  = (ovr[n] && !wo) || (fire[n] && pend[n] && !wp);
            pend[n] = (pend[n] && !wp) || fire[n];
            en[n]   = ne;
            if (w && a == 4'd8) os[n] = d[8+n];
            if (w && a == 4'd9) mask[n] = d[n];
        end
        if (w && int'(a) < NCH) per[a] = d;
    endtask

    task automatic bus(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        write = w; read = r; address = a; writedata = d;
        if (r) exp_rd = m_read(a);
        @(posedge clk);
        m_step(w, a, d);
        #1;
        write = 1'b0; read = 1'b0;
        chk("model_irq", {31'b0, irq}, {31'b0, m_irq()});
        chk("model_readdata", readdata, exp_rd);
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [3:0]  a;
        logic [31:0] d;
        logic        eirq;
        logic        crd;
        logic [31:0] erd;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d,
                       input logic eirq, input logic crd, input logic [31:0] erd);
        vec_t v;
        v.w = w; v.r = r; v.a = a; v.d = d; v.eirq = eirq; v.crd = crd; v.erd = erd;
        tbl.push_back(v);
    endtask
    task automatic vw(input logic [3:0] a, input logic [31:0] d, input logic eirq);
        add(1'b1, 1'b0, a, d, eirq, 1'b0, '0);
    endtask
    task automatic vr(input logic [3:0] a, input logic eirq, input logic [31:0] erd);
        add(1'b0, 1'b1, a, '0, eirq, 1'b1, erd);
    endtask
    task automatic vi(input int cnt, input logic eirq);
        repeat (cnt) add(1'b0, 1'b0, 4'd0, '0, eirq, 1'b0, '0);
    endtask

    initial begin
        // ch0 P=5 periodic, ID, overrun after an uncleared second fire
        vw(0, 5, 0); vw(9, 1, 0); vw(8, 1, 0);
        vi(4, 0); vi(1, 1); vr(11, 1, 32'h8000_0000);
        vw(10, 1, 0); vi(2, 0); vi(1, 1); vr(10, 1, 32'h1);
        vi(4, 1); vr(10, 1, 32'h101); vw(10, 32'h101, 0); vw(8, 0, 0);
        // ch1 one-shot P=3
        vw(1, 3, 0); vw(9, 2, 0); vw(8, 32'h202, 0);
        vi(2, 0); vi(1, 1); vr(8, 1, 32'h200); vw(10, 2, 0);
        vi(5, 0); vr(10, 0, 0); vr(1, 0, 3);
        // ch2 P=4, two fires uncleared
        vw(2, 4, 0); vw(9, 4, 0); vw(8, 4, 0);
        vi(3, 0); vi(5, 1); vr(10, 1, 32'h404); vw(10, 32'h404, 0); vw(8, 0, 0);
        // ch0 P=2, W1C in the fire cycle
        vw(0, 2, 0); vw(9, 1, 0); vw(8, 1, 0);
        vi(1, 0); vi(1, 1); vw(10, 1, 0); vw(10, 1, 1); vw(8, 0, 1);
        vr(10, 1, 32'h1); vw(10, 1, 0);
        // ch1 + ch3 simultaneous, priority
        vw(1, 3, 0); vw(3, 3, 0); vw(9, 32'hA, 0); vw(8, 32'hA, 0);
        vi(2, 0); vi(1, 1); vr(11, 1, 32'h8000_0001); vw(10, 2, 1);
        vr(11, 1, 32'h8000_0003); vw(8, 0, 1); vw(10, 32'hFFFF, 0); vr(10, 0, 0);
        // register map edges
        vr(11, 0, 0); vw(9, 32'hFFFF_FFFF, 0); vr(9, 0, 32'hF); vw(9, 0, 0);
        vw(5, 32'h1234, 0); vr(5, 0, 0); vr(12, 0, 0); vr(15, 0, 0);
        vw(0, 32'h8000_0001, 0); vr(0, 0, 32'h8000_0001);
        vw(8, 32'hFFFF_0000, 0); vr(8, 0, 0);
        // zero period never fires
        vw(2, 0, 0); vw(9, 4, 0); vw(8, 4, 0); vi(6, 0);
        vr(10, 0, 0); vr(8, 0, 32'h4); vw(8, 0, 0);

        reset_n = 1'b0; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
        model_reset();
        #5;
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_readdata", readdata, 32'h0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].eirq});
            if (tbl[i].crd) chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].erd);
        end

        // Short asynchronous reset pulse mid-count
        bus(1, 0, 0, 3); bus(1, 0, 9, 1); bus(1, 0, 8, 1);
        repeat (3) bus(0, 0, 0, 0);
        bus(0, 1, 10, 0);
        chk("pre_pulse_rd", readdata, 32'h1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("pulse_irq", {31'b0, irq}, 32'h0);
        chk("pulse_readdata", readdata, 32'h0);
        #3 reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            bus(0, 0, 0, 0);
            chk("post_pulse_irq", {31'b0, irq}, 32'h0);
        end
        bus(0, 1, 8, 0);  chk("post_pulse_ctrl", readdata, 32'h0);
        bus(0, 1, 10, 0); chk("post_pulse_status", readdata, 32'h0);
        bus(0, 1, 0, 0);  chk("post_pulse_period", readdata, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < NCH; n++) bus(1, 0, 4'(n), $urandom_range(1, 7));
        for (int i = 0; i < 1500; i++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                4:       bus(1, 0, 4'd8,  $urandom());
                5:       bus(1, 0, 4'd10, $urandom());
                6:       bus(1, 0, 4'd9,  $urandom());
                7:       bus(1, 0, 4'($urandom_range(0, 7)), $urandom_range(1, 7));
                8, 9:    bus(0, 1, 4'($urandom_range(0, 15)), 0);
                default: bus(0, 0, 4'd0, 0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of timer channels; legal range 1..8.
REQ-002 Parameter CW, default 32: period and counter width in bits.
REQ-003 Port clk, input, 1: single clock (50 MHz system clock); all state changes on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port address, input, 4: register word address.
REQ-006 Port write, input, 1: write strobe, one transfer per cycle high.
REQ-007 Port writedata, input, 32: write data.
REQ-008 Port read, input, 1: read strobe.
REQ-009 Port readdata, output, 32: read data, registered.
REQ-010 Port irq, output, 1: level interrupt request to the processor.

Function
REQ-011 Register map SHALL be: 0..NCH-1 PERIOD[n] (RW, CW bits); 8 CTRL (RW, [7:0] enable, [15:8] oneshot); 9 MASK (RW, [7:0]); 10 STATUS (R/W1C, [7:0] pending, [15:8] overrun); 11 ID (RO, [31] valid, [2:0] channel).
REQ-012 Bits for channels >= NCH, and unused bits, SHALL read 0 and ignore writes; unmapped addresses SHALL read 0.
REQ-013 readdata SHALL present the addressed register one cycle after read is sampled high and hold its value otherwise.
REQ-014 Each channel SHALL own a CW-bit down-counter cnt[n].
REQ-015 At the edge where enable[n] goes 0->1, cnt[n] SHALL load PERIOD[n]-1.
REQ-016 Writing 1 to an already-set enable bit SHALL NOT restart the count.
REQ-017 While enabled and cnt[n]!=0, cnt[n] SHALL decrement by 1 per cycle.
REQ-018 While enabled and cnt[n]==0 (a "fire"), the channel SHALL set pending[n], reload cnt[n] with PERIOD[n]-1, and, if oneshot[n]=1, clear enable[n].
REQ-019 Pending SHALL therefore assert exactly P edges after the enabling edge, and every P cycles thereafter in periodic mode, where P = PERIOD[n].
REQ-020 PERIOD[n]=0 SHALL be treated as disabled: no fire, counter held.
REQ-021 PERIOD[n]=1 SHALL fire every cycle.
REQ-022 A PERIOD write SHALL NOT disturb the running count; the new value takes effect at the next reload or enable.
REQ-023 Clearing enable[n] SHALL freeze cnt[n] and retain pending/overrun.
REQ-024 A fire while pending[n] is already 1 SHALL set sticky overrun[n].
REQ-025 Writing 1 to a STATUS bit SHALL clear it; writing 0 SHALL have no effect.
REQ-026 A fire coinciding with a W1C of the same pending bit SHALL leave pending=1 (set wins) and SHALL NOT set overrun.
REQ-027 irq SHALL equal OR(pending & MASK), driven from registered state only (glitch-free), and SHALL be visible in the same cycle as the pending bit.
REQ-028 ID.valid SHALL equal irq, and ID.channel SHALL be the lowest-index channel with pending & MASK set (fixed priority, channel 0 highest), or 0 when none.
REQ-029 Simultaneous fires on several channels SHALL all set their pending bits in the same cycle.

Reset
REQ-030 While reset_n=0, PERIOD, CTRL, MASK, STATUS, all cnt, readdata and irq SHALL be 0, and reset SHALL take effect without a clock edge.
REQ-031 Reset asserted mid-count SHALL discard the count; after release, no channel fires until re-enabled.

Verification
REQ-032 PERIOD[0]=5, MASK=1, CTRL=0x01 -> pending[0] and irq rise exactly 5 edges after the CTRL write, then every 5 cycles; ID reads 0x80000000.
REQ-033 PERIOD[1]=3, CTRL=0x0202 (oneshot) -> a single fire after 3 edges; CTRL reads 0x0200 afterwards; no further pending after a W1C.
REQ-034 Channel 2 periodic with P=4 and no W1C for 8 cycles -> STATUS reads 0x0404; writing 0x0404 clears both bits and irq falls the next cycle.
REQ-035 W1C of pending[0] issued in the exact fire cycle with P=2 -> pending stays 1 and overrun stays 0.
REQ-036 Channels 1 and 3 fire together with MASK=0x0A -> ID.channel=1; after W1C of bit 1, ID.channel=3.
REQ-037 reset_n pulsed low for less than one clock period mid-count -> all outputs 0 immediately; no fire for 20 cycles after release.
